// File: rtl/rssb_core.sv
// rssb_core: reverse-subtract-and-skip-if-borrow core that acts as bus initiator for the data/program memory.
// Optional build macro RSSB_WAIT_EN: honour mem_ready wait states; otherwise every access completes in one cycle.
module rssb_core #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(8'h00),
  parameter logic [WIDTH-1:0] HALT_ADDR = WIDTH'(8'h7F)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] address,
  output logic             write,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             halted,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] pc_out
);

  typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, acc_q, acc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [WIDTH-1:0] address_d, wdata_d;
  logic             write_d, busy_d, halted_d;
  logic             start_q;
  logic             ready;

`ifdef RSSB_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign ready            = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  // State, datapath and bus registers; reset clears the write strobe asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      start_q <= 1'b0;
      address <= '0;
      write   <= 1'b0;
      wdata   <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      start_q <= start;
      address <= address_d;
      write   <= write_d;
      wdata   <= wdata_d;
      busy    <= busy_d;
      halted  <= halted_d;
    end
  end

  // Next state and datapath; bus outputs are derived from the state being entered
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    address_d = pc_q;
    write_d   = 1'b0;
    wdata_d   = wdata;
    busy_d    = 1'b0;
    halted_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (ready) begin
          ir_d    = rdata;
          pc_d    = pc_q + WIDTH'(1);
          state_d = (rdata == HALT_ADDR) ? HALT : READ;
        end
      end
      READ: begin
        if (ready) begin
          mdr_d   = rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ready) begin
          acc_d = mdr_q - acc_q;
          // pc already points past this instruction, so one more step skips the next
          if (mdr_q < acc_q) pc_d = pc_q + WIDTH'(1);
          state_d = FETCH;
        end
      end
      HALT: begin
        if (start && !start_q) begin
          pc_d    = RESET_PC;
          acc_d   = '0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    address_d = pc_d;
    case (state_d)
      FETCH: busy_d = 1'b1;
      READ: begin
        busy_d    = 1'b1;
        address_d = ir_d;
      end
      WRITE: begin
        busy_d    = 1'b1;
        address_d = ir_d;
        write_d   = 1'b1;
        wdata_d   = mdr_d - acc_d;
      end
      HALT:    halted_d = 1'b1;
      default: busy_d   = 1'b0;
    endcase
  end

  assign acc_out = acc_q;
  assign pc_out  = pc_q;

endmodule

// File: tb/tb_rssb_core.sv
// Self-checking bench for rssb_core: flat 256-word memory model plus an instruction-level reference interpreter.
module tb_rssb_core;

  localparam logic [7:0] HALT_OP = 8'h7F;

  logic       clk = 1'b0;
  logic       rst, start, mem_ready;
  logic [7:0] rdata, address, wdata, acc_out, pc_out;
  logic       write, busy, halted;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_pc, ref_acc;
  bit         ref_halt;
  bit         wr_seen;
  bit         rdy[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  rssb_core dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .rdata(rdata),
    .address(address), .write(write), .wdata(wdata), .busy(busy), .halted(halted),
    .acc_out(acc_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;
  assign rdata = mem[address];

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end of run, required summary before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: a write visible before the edge lands in memory after it
  task automatic cyc();
    logic       wr;
    logic [7:0] wa, wd;
    wr = (write === 1'b1) && (mem_ready === 1'b1);
    wa = address;
    wd = wdata;
    @(posedge clk);
    @(negedge clk);
    wr_seen = wr;
    if (wr) mem[wa] = wd;
  endtask

  function automatic bit draw();
`ifdef RSSB_WAIT_EN
    return $urandom_range(0, 3) != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic put(input logic [7:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic fill(input bit nohalt);
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (a < 128) begin
        v = 8'($urandom_range(128, 255));
        if (!nohalt && a != 0 && $urandom_range(0, 19) == 0) v = HALT_OP;
      end
      if (nohalt && v == HALT_OP) v = 8'h80;
      put(8'(a), v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    mem_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check1("idle_wait_busy", busy, 1'b0);
    start = 1'b1;
    cyc();
    check1("start_busy", busy, 1'b1);
    check8("start_addr", address, 8'h00);
    ref_pc = 8'h00;
    ref_acc = 8'h00;
    ref_halt = 1'b0;
  endtask

  // Execute one instruction in the model, then clock the DUT until it completes it
  task automatic run_instr();
    logic [7:0] op, m, r;
    bit         hlt, done;
    int         need, cycles, exp_cyc;
    op = ref_mem[ref_pc];
    hlt = (op == HALT_OP);
    m = ref_mem[op];
    r = m - ref_acc;
    ref_pc = ref_pc + 8'd1;
    if (hlt) ref_halt = 1'b1;
    else begin
      if (m < ref_acc) ref_pc = ref_pc + 8'd1;
      ref_acc = r;
      ref_mem[op] = r;
    end
    need = hlt ? 1 : 3;
    if (rdy.size() == 0) begin
      while (need > 0) begin
        bit b;
        b = draw();
        rdy.push_back(b);
        if (b) need--;
      end
    end
    exp_cyc = rdy.size();
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 64) begin
      mem_ready = (rdy.size() != 0) ? rdy.pop_front() : 1'b1;
      start = hlt ? 1'b1 : 1'($urandom_range(0, 1));
      if (hlt) check1("halt_no_write", write, 1'b0);
      else if (write === 1'b1) begin
        check8("wr_addr", address, op);
        check8("wr_data", wdata, r);
      end
      cyc();
      cycles++;
      done = hlt ? (halted === 1'b1) : wr_seen;
    end
    rdy.delete();
    mem_ready = 1'b1;
    check1("instr_done", done, 1'b1);
    checki("instr_cycles", cycles, exp_cyc);
    check8("pc", pc_out, ref_pc);
    check8("acc", acc_out, ref_acc);
    check1("halted", halted, hlt);
    check1("busy", busy, !hlt);
    if (!hlt) check8("ram", mem[op], ref_mem[op]);
  endtask

  task automatic run_prog(input int n);
    for (int i = 0; i < n && !ref_halt; i++) run_instr();
  endtask

  task automatic restart();
    start = 1'b0;
    cyc();
    check1("rs_still_halted", halted, 1'b1);
    start = 1'b1;
    cyc();
    check8("rs_pc", pc_out, 8'h00);
    check8("rs_acc", acc_out, 8'h00);
    check1("rs_busy", busy, 1'b1);
    check1("rs_halted", halted, 1'b0);
    ref_pc = 8'h00;
    ref_acc = 8'h00;
    ref_halt = 1'b0;
  endtask

  initial begin
    logic [7:0] tgt, old;
    logic [6:0] pat;
    rst = 1'b0;
    start = 1'b1;
    mem_ready = 1'b1;
    for (int a = 0; a < 256; a++) put(8'(a), 8'h00);
    @(negedge clk);
    cyc();
    cyc();
    check8("rst_addr", address, 8'h00);
    check1("rst_write", write, 1'b0);
    check8("rst_pc", pc_out, 8'h00);
    check8("rst_acc", acc_out, 8'h00);
    check1("rst_busy", busy, 1'b0);
    check1("rst_halted", halted, 1'b0);

    // Directed program: no-borrow, borrow skip, halt
    put(8'h00, 8'h82); put(8'h82, 8'h08);
    put(8'h01, 8'h80); put(8'h80, 8'h01);
    put(8'h02, 8'h83); put(8'h03, HALT_OP);
    rst = 1'b1;
    cyc();
    check1("rel_busy", busy, 1'b1);
    check8("rel_addr", address, 8'h00);
    ref_pc = 8'h00; ref_acc = 8'h00; ref_halt = 1'b0;
    run_instr();
    check8("tp1_ram", mem[8'h82], 8'h08);
    check8("tp1_acc", acc_out, 8'h08);
    check8("tp1_pc", pc_out, 8'h01);
    run_instr();
    check8("tp2_ram", mem[8'h80], 8'hF9);
    check8("tp2_acc", acc_out, 8'hF9);
    check8("tp2_pc", pc_out, 8'h03);
    run_instr();
    check1("tp3_halted", halted, 1'b1);
    check8("tp3_pc", pc_out, 8'h04);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check1("hold_halted", halted, 1'b1);
      check1("hold_write", write, 1'b0);
      check8("hold_pc", pc_out, 8'h04);
    end
    restart();
    run_prog(6);

    // Reset during the write cycle must not commit the write
    fill(1'b1);
    do_reset();
    start = 1'b1;
    cyc();
    cyc();
    check1("mw_write_pre", write, 1'b1);
    tgt = address;
    old = mem[tgt];
    rst = 1'b0;
    #1;
    check1("mw_write_drop", write, 1'b0);
    cyc();
    check8("mw_ram", mem[tgt], old);
    check1("mw_busy", busy, 1'b0);
    check1("mw_halted", halted, 1'b0);
    check8("mw_pc", pc_out, 8'h00);
    check8("mw_addr", address, 8'h00);

    for (int r = 0; r < 6; r++) begin
      fill(r == 5);
      do_reset();
`ifdef RSSB_WAIT_EN
      if (r == 0) begin
        pat = 7'b1001001;
        for (int i = 6; i >= 0; i--) rdy.push_back(pat[i]);
        run_instr();
      end
`endif
      run_prog((r == 5) ? 300 : 80);
      if (ref_halt) begin
        restart();
        run_prog(20);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
